jc_phase_sched: RTL and testbench

- Controller that sequences an internal N-bit twisted-ring (Johnson) counter through its 2N-state cycle.
- Runs a programmed number of full revolutions, then stops.
- Decodes the current state into a one-hot phase strobe and a binary phase index for downstream multi-phase logic.
- Provides start/ready handshake, hold (stall), abort, completion pulse and illegal-state detection; it is the sequencing front-end for any Johnson-counter-driven datapath.

---
 rtl/jc_phase_sched.sv | 116 +++++++++++
 tb/tb_jc_phase_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/jc_phase_sched.sv
// jc_phase_sched: Johnson-counter phase sequencer that runs a set number of revolutions
// and decodes the counter into a one-hot phase strobe and a binary phase index.
module jc_phase_sched #(
    parameter int N  = 4,
    parameter int CW = 8,
    parameter int IW = $clog2(2*N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [CW-1:0]   ncycles_i,
    input  logic            hold_i,
    input  logic            abort_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic [N-1:0]    jc_state_o,
    output logic [2*N-1:0]  phase_o,
    output logic [IW-1:0]   phase_idx_o,
    output logic            wrap_o,
    output logic [CW-1:0]   cyc_cnt_o,
    output logic            done_o,
    output logic            err_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

    st_t           state_q, state_d;
    logic [N-1:0]  jc_q, jc_d, step;
    logic [CW-1:0] cyc_q, cyc_d, ncyc_q, ncyc_d, cyc_inc;
    logic          err_q, err_d, done_q, done_d, wrap_q, wrap_d;
    logic          legal, wrap_now;
    logic [IW-1:0] idx;
    int            k;

    assign step     = {~jc_q[0], jc_q[N-1:1]};
    assign wrap_now = step == '0;
    assign cyc_inc  = cyc_q + 1'b1;
    // A Johnson code has at most one bit transition along its length.
    assign legal    = $countones(jc_q[N-1:1] ^ jc_q[N-2:0]) <= 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            jc_q    <= '0;
            cyc_q   <= '0;
            ncyc_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            jc_q    <= jc_d;
            cyc_q   <= cyc_d;
            ncyc_q  <= ncyc_d;
            err_q   <= err_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !start_i ? IDLE : (ncycles_i != '0 ? RUN : DONE);
            RUN:     state_d = abort_i ? IDLE :
                               (legal && !hold_i && wrap_now && cyc_inc == ncyc_q) ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        jc_d   = jc_q;
        cyc_d  = cyc_q;
        ncyc_d = ncyc_q;
        err_d  = err_q;
        done_d = 1'b0;
        wrap_d = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                ncyc_d = ncycles_i;
                cyc_d  = '0;
                err_d  = 1'b0;
                jc_d   = '0;
                done_d = ncycles_i == '0;
            end
            RUN: if (abort_i) begin
                jc_d = '0;
            end else if (!legal) begin
                err_d = 1'b1;
                jc_d  = '0;
            end else if (!hold_i) begin
                jc_d = step;
                if (wrap_now) begin
                    cyc_d  = cyc_inc;
                    wrap_d = 1'b1;
                    done_d = cyc_inc == ncyc_q;
                end
            end
            default: jc_d = '0;
        endcase
    end

    always_comb begin
        k   = $countones(jc_q);
        idx = jc_q[0] ? IW'(2*N - k) : IW'(k);
    end

    assign ready_o     = state_q == IDLE;
    assign busy_o      = state_q == RUN;
    assign jc_state_o  = jc_q;
    assign phase_idx_o = busy_o ? idx : '0;
    assign phase_o     = busy_o ? ({{(2*N-1){1'b0}}, 1'b1} << phase_idx_o) : '0;
    assign wrap_o      = wrap_q;
    assign cyc_cnt_o   = cyc_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_jc_phase_sched.sv
// tb_jc_phase_sched: directed stimulus for jc_phase_sched (N=4, CW=8) checked every cycle
// against a phase-index model, plus hand-computed literal expectations at key cycles.
module tb_jc_phase_sched;
    localparam int N = 4, CW = 8, P = 2*N, IW = $clog2(P);

    logic           clk = 1'b0, rst_n = 1'b1;
    logic           start = 1'b0, hold = 1'b0, abort = 1'b0, inj = 1'b0, chk_en = 1'b0;
    logic [CW-1:0]  nc = '0;
    logic           ready_o, busy_o, wrap_o, done_o, err_o;
    logic [N-1:0]   jc_state_o;
    logic [P-1:0]   phase_o;
    logic [IW-1:0]  phase_idx_o;
    logic [CW-1:0]  cyc_cnt_o;
    int             n_pass = 0, n_tot = 0, n;

    // model: mode 0=IDLE 1=RUN 2=DONE, m_p = phase index
    int m_mode = 0, m_p = 0, m_cyc = 0, m_ncyc = 0;
    bit m_err = 0, m_done = 0, m_wrap = 0;

    jc_phase_sched #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .ncycles_i(nc), .hold_i(hold),
        .abort_i(abort), .ready_o(ready_o), .busy_o(busy_o), .jc_state_o(jc_state_o),
        .phase_o(phase_o), .phase_idx_o(phase_idx_o), .wrap_o(wrap_o),
        .cyc_cnt_o(cyc_cnt_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] jcv(input int p);
        return (p <= N) ? (((1 << p) - 1) << (N - p)) : ((1 << (P - p)) - 1);
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_mode = 0; m_p = 0; m_cyc = 0; m_ncyc = 0; m_err = 0; m_done = 0; m_wrap = 0;
        end else begin
            m_done = 0; m_wrap = 0;
            if (m_mode == 0) begin
                if (start) begin
                    m_ncyc = int'(nc); m_cyc = 0; m_err = 0; m_p = 0;
                    m_mode = (nc != 0) ? 1 : 2;
                    m_done = (nc == 0);
                end
            end else if (m_mode == 1) begin
                if (abort) begin
                    m_mode = 0; m_p = 0;
                end else if (inj) begin
                    m_err = 1; m_p = 0;
                end else if (!hold) begin
                    m_p = (m_p + 1) % P;
                    if (m_p == 0) begin
                        m_cyc = (m_cyc + 1) % (1 << CW);
                        m_wrap = 1;
                        if (m_cyc == m_ncyc) begin m_mode = 2; m_done = 1; end
                    end
                end
            end else begin
                m_mode = 0; m_p = 0;
            end
        end
        #1;
        if (chk_en) begin
            chk("ready", ready_o, m_mode == 0);
            chk("busy", busy_o, m_mode == 1);
            chk("jc_state", jc_state_o, m_mode == 1 ? jcv(m_p) : 0);
            chk("phase", phase_o, m_mode == 1 ? (1 << m_p) : 0);
            chk("phase_idx", phase_idx_o, m_mode == 1 ? m_p : 0);
            chk("wrap", wrap_o, m_wrap);
            chk("cyc_cnt", cyc_cnt_o, m_cyc);
            chk("done", done_o, m_done);
            chk("err", err_o, m_err);
        end
    end

    task automatic wait_done(input int maxc, output int cnt);
        cnt = 0;
        while (!done_o && cnt < maxc) begin @(negedge clk); cnt++; end
        if (!done_o) chk("done_timeout", 0, 1);
    endtask

    task automatic go(input logic [CW-1:0] v);
        start = 1'b1; nc = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_jc", jc_state_o, 0);
        chk("rst_phase", phase_o, 0);
        chk("rst_err", err_o, 0);
        chk_en = 1'b1;
        @(negedge clk);
        // two revolutions
        go(2);
        chk("r2_busy_t1", busy_o, 1);
        chk("r2_phase_t1", phase_o, 8'h01);
        repeat (7) @(negedge clk);
        chk("r2_phase_t8", phase_o, 8'h80);
        chk("r2_jc_t8", jc_state_o, 4'h1);
        @(negedge clk);
        chk("r2_wrap_t9", wrap_o, 1);
        chk("r2_cyc_t9", cyc_cnt_o, 1);
        repeat (8) @(negedge clk);
        chk("r2_done_t17", done_o, 1);
        chk("r2_cyc_t17", cyc_cnt_o, 2);
        @(negedge clk);
        chk("r2_ready_t18", ready_o, 1);
        // hold at phase 5 for three cycles
        go(2);
        repeat (5) @(negedge clk);
        hold = 1'b1;
        repeat (3) @(negedge clk);
        hold = 1'b0;
        chk("hold_phase_t9", phase_o, 8'h20);
        repeat (11) @(negedge clk);
        chk("hold_done_t20", done_o, 1);
        chk("hold_cyc_t20", cyc_cnt_o, 2);
        @(negedge clk);
        // abort at phase 3 of revolution 2
        go(5);
        repeat (11) @(negedge clk);
        chk("ab_idx", phase_idx_o, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_ready", ready_o, 1);
        chk("ab_jc", jc_state_o, 0);
        chk("ab_cyc", cyc_cnt_o, 1);
        chk("ab_done", done_o, 0);
        // zero revolutions
        go(0);
        chk("z_done", done_o, 1);
        chk("z_wrap", wrap_o, 0);
        chk("z_busy", busy_o, 0);
        @(negedge clk);
        // start while busy is ignored
        go(3);
        @(negedge clk);
        start = 1'b1; nc = 8'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(40, n);
        chk("ign_lat", n, 22);
        chk("ign_cyc", cyc_cnt_o, 3);
        @(negedge clk);
        // illegal code injected mid-run
        go(2);
        repeat (3) @(negedge clk);
        force dut.jc_q = 4'b0101;
        inj = 1'b1;
        #1 release dut.jc_q;
        @(negedge clk);
        inj = 1'b0;
        chk("ill_err", err_o, 1);
        chk("ill_jc", jc_state_o, 0);
        chk("ill_busy", busy_o, 1);
        wait_done(40, n);
        chk("ill_err_done", err_o, 1);
        @(negedge clk);
        go(1);
        chk("ill_err_clr", err_o, 0);
        wait_done(20, n);
        @(negedge clk);
        // asynchronous reset mid-run
        go(3);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ready", ready_o, 1);
        chk("ar_busy", busy_o, 0);
        chk("ar_jc", jc_state_o, 0);
        chk("ar_phase", phase_o, 0);
        chk("ar_cyc", cyc_cnt_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        go(1);
        repeat (7) @(negedge clk);
        chk("ar_nodone_t8", done_o, 0);
        @(negedge clk);
        chk("ar_done_t9", done_o, 1);
        chk("ar_cyc_t9", cyc_cnt_o, 1);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
